reg_access_ctrl: RTL and testbench
==================================

REG_ACCESS_CTRL -- requirements
Module: reg_access_ctrl

Interface
REQ-001 SHALL have parameters: NumRegs, default 8, number of registers; DW, default 32, register width; AW, default 3, address width; RegAccess, default all SwAccessRW, per-register prim_reg_pkg::sw_access_e array; RegReset, default all 0, per-register reset value array.
REQ-002 SHALL have ports: clk_i  in  1  clock; rst_ni  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: req_valid_i  in  1  request valid; req_ready_o  out  1  request ready; req_we_i  in  1  write (1) or read (0); req_addr_i  in  AW  register index; req_wdata_i  in  DW  write data; req_be_i  in  DW/8  byte enables.
REQ-004 SHALL have ports: rsp_valid_o  out  1  response valid; rsp_ready_i  in  1  response accepted; rsp_rdata_o  out  DW  read data; rsp_err_o  out  1  access error.
REQ-005 SHALL have ports: hw_we_i  in  NumRegs  hardware write strobes; hw_wdata_i  in  NumRegs*DW  hardware write data; reg_q_o  out  NumRegs*DW  register contents; reg_qe_o  out  NumRegs  one-cycle software-update pulse.

Function
REQ-006 SHALL implement FSM Idle -> Exec -> Resp -> Idle; req_ready_o=1 only in Idle; a request is taken on req_valid_i & req_ready_o and captured.
REQ-007 SHALL spend exactly one cycle in Exec, computing the register update and the response in that cycle.
REQ-008 SHALL assert rsp_valid_o in Resp and hold rsp_rdata_o/rsp_err_o stable until rsp_ready_i; Resp -> Idle on rsp_ready_i.
REQ-009 SHALL give latency: request accepted at edge N, rsp_valid_o high from cycle N+2; minimum 3 cycles per transaction.
REQ-010 SHALL form write mask m by expanding req_be_i per byte.
REQ-011 SHALL apply writes per access type (d=req_wdata_i): RW q=(q&~m)|(d&m); W1S q=q|(d&m); W1C q=q&~(d&m); W0C q=q&~(~d&m); RO, RC no change, rsp_err_o=1; WO as RW.
REQ-012 SHALL return reads as: RW/RO/W1C/W1S/W0C rdata=q; WO rdata=0, err=0; RC rdata=q, then q cleared to 0 in the same Exec cycle.
REQ-013 SHALL treat req_addr_i >= NumRegs as an error: rdata=0, rsp_err_o=1, no register change, no qe pulse.
REQ-014 SHALL treat a write with m=0 as legal: no change, no qe pulse, err per REQ-011.
REQ-015 SHALL pulse reg_qe_o[k] for one cycle, coincident with the update, on a legal software write to k with m!=0.
REQ-016 SHALL load hw_wdata_i slice k into register k in any cycle hw_we_i[k]=1.
REQ-017 SHALL give software priority when a software update (write or RC clear) and hw_we_i hit the same register in the same cycle; the hardware value is dropped.
REQ-018 SHALL sample rdata from the pre-update value of q.
REQ-019 SHALL drive rsp_rdata_o and rsp_err_o to 0 whenever rsp_valid_o=0.

Reset
REQ-020 SHALL, on rst_ni low, immediately set: FSM Idle; registers to RegReset; rsp_valid_o=0; reg_qe_o=0; rsp_rdata_o=0; rsp_err_o=0.
REQ-021 SHALL abort any in-flight transaction on reset and not issue its response afterwards.

Structure
REQ-022 SHALL take sw_access_e from prim_reg_pkg; the FSM state enum is local to the module.
REQ-023 SHALL place per-access next-value/rdata/error computation in one combinational sub-module, reg_access_alu, instantiated once on the addressed register.

Verification
REQ-024 SHALL cover: RW reg 0 write 0xA5A5A5A5 be=0xF, then read -> rdata 0xA5A5A5A5, err 0, qe[0] one pulse, response at N+2.
REQ-025 SHALL cover: W1C reg 1 =0xFF, write 0x0F be=0x1 -> q=0xF0; W1S write 0x100 be=0x2 -> q=0x1F0.
REQ-026 SHALL cover: RC reg 2 =0x55 read with hw_we_i[2] same Exec cycle -> rdata 0x55, q=0 afterwards.
REQ-027 SHALL cover: RO write -> err 1, q unchanged; addr 9 with NumRegs=8 -> err 1, rdata 0, no qe.
REQ-028 SHALL cover: rsp_ready_i held low 5 cycles -> rsp held stable, req_ready_o 0; rst_ni low in Exec -> no response, registers = RegReset.

Source files
------------

// File: rtl/prim_reg_pkg.sv
// Software access policies shared by register blocks.
// Each register in a block is tagged with one of these at elaboration time.
package prim_reg_pkg;

    typedef enum logic [2:0] {
        SwAccessRW,
        SwAccessRO,
        SwAccessWO,
        SwAccessW1C,
        SwAccessW1S,
        SwAccessW0C,
        SwAccessRC
    } sw_access_e;

endpackage

// File: rtl/reg_access_alu.sv
// Combinational next-value / read-data / error computation for one software
// access to a single register, according to that register's access policy.
module reg_access_alu
    import prim_reg_pkg::*;
#(
    parameter int DW = 32
) (
    input  sw_access_e          access,
    input  logic                addrOk,
    input  logic                we,
    input  logic [DW-1:0]       q,
    input  logic [DW-1:0]       wdata,
    input  logic [DW-1:0]       mask,
    output logic [DW-1:0]       nextQ,
    output logic [DW-1:0]       rdata,
    output logic                update,
    output logic                qe,
    output logic                err
);

    always_comb begin
        nextQ  = q;
        rdata  = '0;
        update = 1'b0;
        qe     = 1'b0;
        err    = 1'b0;
        if (!addrOk) begin
            err = 1'b1;
        end else if (we) begin
            case (access)
                SwAccessRW, SwAccessWO: nextQ = (q & ~mask) | (wdata & mask);
                SwAccessW1S:            nextQ = q | (wdata & mask);
                SwAccessW1C:            nextQ = q & ~(wdata & mask);
                SwAccessW0C:            nextQ = q & ~(~wdata & mask);
                default:                err   = 1'b1;
            endcase
            // An all-zero mask is a legal no-op write: nothing committed, no strobe.
            if (!err && (mask != '0)) begin
                update = 1'b1;
                qe     = 1'b1;
            end
        end else begin
            rdata = (access == SwAccessWO) ? '0 : q;
            if (access == SwAccessRC) begin
                nextQ  = '0;
                update = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_access_ctrl.sv
// Register block with a request/response software port (Idle -> Exec -> Resp)
// and per-register hardware write strobes; software updates win over hardware.
module reg_access_ctrl
    import prim_reg_pkg::*;
#(
    parameter int              NumRegs            = 8,
    parameter int              DW                 = 32,
    parameter int              AW                 = 3,
    parameter sw_access_e      RegAccess [NumRegs] = '{default: SwAccessRW},
    parameter logic [DW-1:0]   RegReset  [NumRegs] = '{default: '0}
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [AW-1:0]         req_addr_i,
    input  logic [DW-1:0]         req_wdata_i,
    input  logic [DW/8-1:0]       req_be_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DW-1:0]         rsp_rdata_o,
    output logic                  rsp_err_o,
    input  logic [NumRegs-1:0]    hw_we_i,
    input  logic [NumRegs*DW-1:0] hw_wdata_i,
    output logic [NumRegs*DW-1:0] reg_q_o,
    output logic [NumRegs-1:0]    reg_qe_o
);

    typedef enum logic [1:0] {Idle, Exec, Resp} state_e;

    state_e            state, stateNext;
    logic              accept, exec;
    logic              reqWeP0;
    logic [AW-1:0]     reqAddrP0;
    logic [DW-1:0]     reqWdataP0;
    logic [DW/8-1:0]   reqBeP0;
    logic [DW-1:0]     rspRdataP1;
    logic              rspErrP1;
    logic [DW-1:0]     regQ [NumRegs];
    logic [DW-1:0]     mask, curQ, aluNext, aluRdata;
    sw_access_e        curAccess;
    logic              addrOk, aluUpdate, aluQe, aluErr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= Idle;
        else         state <= stateNext;
    end

    always_comb begin
        stateNext   = state;
        req_ready_o = 1'b0;
        accept      = 1'b0;
        exec        = 1'b0;
        case (state)
            Idle: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    accept    = 1'b1;
                    stateNext = Exec;
                end
            end
            Exec: begin
                exec      = 1'b1;
                stateNext = Resp;
            end
            Resp:    if (rsp_ready_i) stateNext = Idle;
            default: stateNext = Idle;
        endcase
    end

    // p0: request captured at acceptance
    always_ff @(posedge clk_i) begin
        if (accept) begin
            reqWeP0    <= req_we_i;
            reqAddrP0  <= req_addr_i;
            reqWdataP0 <= req_wdata_i;
            reqBeP0    <= req_be_i;
        end
    end

    for (genvar b = 0; b < DW/8; b++) begin : gMask
        assign mask[8*b +: 8] = {8{reqBeP0[b]}};
    end

    always_comb begin
        addrOk    = 1'b0;
        curQ      = '0;
        curAccess = SwAccessRO;
        for (int k = 0; k < NumRegs; k++) begin
            if (int'(reqAddrP0) == k) begin
                addrOk    = 1'b1;
                curQ      = regQ[k];
                curAccess = RegAccess[k];
            end
        end
    end

    reg_access_alu #(.DW(DW)) uAlu (
        .access (curAccess),
        .addrOk (addrOk),
        .we     (reqWeP0),
        .q      (curQ),
        .wdata  (reqWdataP0),
        .mask   (mask),
        .nextQ  (aluNext),
        .rdata  (aluRdata),
        .update (aluUpdate),
        .qe     (aluQe),
        .err    (aluErr)
    );

    // p1: response and register update committed at the end of Exec
    always_ff @(posedge clk_i) begin
        if (exec) begin
            rspRdataP1 <= aluRdata;
            rspErrP1   <= aluErr;
        end
    end

    for (genvar k = 0; k < NumRegs; k++) begin : gReg
        logic          swHit, qeQ;
        logic [DW-1:0] q;

        assign swHit = exec && aluUpdate && (int'(reqAddrP0) == k);

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                q   <= RegReset[k];
                qeQ <= 1'b0;
            end else begin
                qeQ <= swHit && aluQe;
                if (swHit)           q <= aluNext;
                else if (hw_we_i[k]) q <= hw_wdata_i[k*DW +: DW];
            end
        end

        assign regQ[k]              = q;
        assign reg_q_o[k*DW +: DW]  = q;
        assign reg_qe_o[k]          = qeQ;
    end

    assign rsp_valid_o = (state == Resp);
    assign rsp_rdata_o = rsp_valid_o ? rspRdataP1 : '0;
    assign rsp_err_o   = rsp_valid_o & rspErrP1;

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Directed bench for reg_access_ctrl: a per-cycle expectation model of the
// register file and response channel, plus hand-computed literal checks.
module tb_reg_access_ctrl;
    import prim_reg_pkg::*;

    localparam sw_access_e ACC [8] = '{SwAccessRW, SwAccessW1C, SwAccessRC, SwAccessRO,
                                       SwAccessWO, SwAccessW1S, SwAccessW0C, SwAccessRW};
    localparam logic [31:0] RST [8] = '{32'h0, 32'hFF, 32'h0, 32'hDEADBEEF,
                                        32'h0, 32'h0, 32'hFFFFFFFF, 32'h12345678};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         reqValid, reqReady, reqWe, rspValid, rspReady, rspErr;
    logic [3:0]   reqAddr, reqBe;
    logic [31:0]  reqWdata, rspRdata;
    logic [7:0]   hwWe, regQe;
    logic [255:0] hwWdata, regQ;

    reg_access_ctrl #(
        .NumRegs(8), .DW(32), .AW(4), .RegAccess(ACC), .RegReset(RST)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(reqValid), .req_ready_o(reqReady), .req_we_i(reqWe),
        .req_addr_i(reqAddr), .req_wdata_i(reqWdata), .req_be_i(reqBe),
        .rsp_valid_o(rspValid), .rsp_ready_i(rspReady),
        .rsp_rdata_o(rspRdata), .rsp_err_o(rspErr),
        .hw_we_i(hwWe), .hw_wdata_i(hwWdata), .reg_q_o(regQ), .reg_qe_o(regQe)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Expected observable state for the current cycle.
    logic [31:0] expQ [8];
    logic        expReady, expValid, expErr, expRdKnown;
    logic [31:0] expRdata;
    logic [7:0]  expQe;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("req_ready", {31'b0, reqReady}, {31'b0, expReady});
        chk("rsp_valid", {31'b0, rspValid}, {31'b0, expValid});
        if (!expValid) begin
            chk("rdata_idle", rspRdata, 32'h0);
            chk("err_idle", {31'b0, rspErr}, 32'h0);
        end else begin
            chk("rsp_err", {31'b0, rspErr}, {31'b0, expErr});
            if (expRdKnown) chk("rsp_rdata", rspRdata, expRdata);
        end
        chk("reg_qe", {24'b0, regQe}, {24'b0, expQe});
        for (int k = 0; k < 8; k++) chk($sformatf("reg_q%0d", k), regQ[k*32 +: 32], expQ[k]);
    end

    // Outcome of one software access, from the access-policy rules.
    function automatic void specAccess(input int addr, input bit we, input logic [31:0] d,
                                       input logic [3:0] be, output logic [31:0] nq,
                                       output logic [31:0] rd, output logic err,
                                       output logic touched, output logic qe);
        logic [31:0] m, q;
        m = 32'h0;
        for (int b = 0; b < 4; b++) if (be[b]) m = m | (32'hFF << (8*b));
        nq = 32'h0; rd = 32'h0; err = 1'b0; touched = 1'b0; qe = 1'b0;
        if (addr >= 8) begin
            err = 1'b1;
            return;
        end
        q  = expQ[addr];
        nq = q;
        if (!we) begin
            rd = (ACC[addr] == SwAccessWO) ? 32'h0 : q;
            if (ACC[addr] == SwAccessRC) begin
                nq = 32'h0;
                touched = 1'b1;
            end
        end else begin
            if (ACC[addr] == SwAccessRO || ACC[addr] == SwAccessRC) err = 1'b1;
            else if (ACC[addr] == SwAccessW1S) nq = q | (d & m);
            else if (ACC[addr] == SwAccessW1C) nq = q & ~(d & m);
            else if (ACC[addr] == SwAccessW0C) nq = q & ~(~d & m);
            else nq = (q & ~m) | (d & m);
            touched = !err && (m != 0);
            qe = touched;
        end
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic hwWrite(input int k, input logic [31:0] val);
        hwWe[k] = 1'b1;
        hwWdata[k*32 +: 32] = val;
        tick();
        expQ[k] = val;
        hwWe = 8'h0;
    endtask

    // Full transaction; optional hardware writes during Exec and a response stall.
    task automatic txn(input bit we, input int addr, input logic [31:0] d, input logic [3:0] be,
                       input int delay, input logic [7:0] hwMask, input logic [31:0] hwVal,
                       output logic [31:0] rd, output logic er, output logic [7:0] qeSeen);
        logic [31:0] nq, rdE;
        logic errE, touched, qeE;
        specAccess(addr, we, d, be, nq, rdE, errE, touched, qeE);
        reqValid = 1'b1; reqWe = we; reqAddr = addr[3:0]; reqWdata = d; reqBe = be;
        rspReady = (delay == 0);
        tick();
        reqValid = 1'b0;
        expReady = 1'b0;
        hwWe = hwMask;
        for (int k = 0; k < 8; k++) if (hwMask[k]) hwWdata[k*32 +: 32] = hwVal;
        tick();
        hwWe = 8'h0;
        for (int k = 0; k < 8; k++) begin
            if (touched && k == addr) expQ[k] = nq;
            else if (hwMask[k])       expQ[k] = hwVal;
        end
        expQe = qeE ? (8'h1 << addr) : 8'h0;
        expValid = 1'b1; expRdata = rdE; expErr = errE; expRdKnown = !we;
        rd = rspRdata; er = rspErr; qeSeen = regQe;
        for (int i = 0; i < delay; i++) begin
            tick();
            expQe = 8'h0;
            if (i == delay - 1) rspReady = 1'b1;
        end
        tick();
        rspReady = 1'b0;
        expValid = 1'b0; expRdKnown = 1'b0; expQe = 8'h0; expReady = 1'b1;
    endtask

    task automatic resetToModel();
        for (int k = 0; k < 8; k++) expQ[k] = RST[k];
        expReady = 1'b1; expValid = 1'b0; expErr = 1'b0; expRdKnown = 1'b0;
        expRdata = 32'h0; expQe = 8'h0;
    endtask

    initial begin
        logic [31:0] rd;
        logic er;
        logic [7:0] qs;
        rst_n = 1'b0;
        reqValid = 1'b0; reqWe = 1'b0; reqAddr = 4'h0; reqWdata = 32'h0; reqBe = 4'h0;
        rspReady = 1'b0; hwWe = 8'h0; hwWdata = '0;
        resetToModel();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_q3", regQ[3*32 +: 32], 32'hDEADBEEF);
        chk("rst_ready", {31'b0, reqReady}, 32'h1);

        // RW full write then read
        txn(1, 0, 32'hA5A5A5A5, 4'hF, 0, 8'h0, 32'h0, rd, er, qs);
        chk("rw_qe", {24'b0, qs}, 32'h1);
        chk("rw_wr_err", {31'b0, er}, 32'h0);
        txn(0, 0, 32'h0, 4'h0, 0, 8'h0, 32'h0, rd, er, qs);
        chk("rw_rd", rd, 32'hA5A5A5A5);
        chk("rw_rd_qe", {24'b0, qs}, 32'h0);

        // RW partial byte-enable write
        txn(1, 0, 32'h11223344, 4'h5, 0, 8'h0, 32'h0, rd, er, qs);
        chk("rw_be", regQ[31:0], 32'hA522A544);

        // W1C and W1S
        txn(1, 1, 32'h0F, 4'h1, 0, 8'h0, 32'h0, rd, er, qs);
        chk("w1c_q", regQ[63:32], 32'hF0);
        chk("w1c_model", expQ[1], 32'hF0);
        hwWrite(5, 32'hF0);
        txn(1, 5, 32'h100, 4'h2, 0, 8'h0, 32'h0, rd, er, qs);
        chk("w1s_q", regQ[5*32 +: 32], 32'h1F0);

        // W0C
        txn(1, 6, 32'h0000FF00, 4'h3, 0, 8'h0, 32'h0, rd, er, qs);
        chk("w0c_q", regQ[6*32 +: 32], 32'hFFFFFF00);

        // RC read racing hardware writes to itself and to reg 7
        hwWrite(2, 32'h55);
        txn(0, 2, 32'h0, 4'h0, 0, 8'h84, 32'h77, rd, er, qs);
        chk("rc_rd", rd, 32'h55);
        chk("rc_q", regQ[2*32 +: 32], 32'h0);
        chk("rc_hw7", regQ[7*32 +: 32], 32'h77);

        // RO write, RO read
        txn(1, 3, 32'h0, 4'hF, 0, 8'h0, 32'h0, rd, er, qs);
        chk("ro_err", {31'b0, er}, 32'h1);
        chk("ro_q", regQ[3*32 +: 32], 32'hDEADBEEF);
        txn(0, 3, 32'h0, 4'h0, 0, 8'h0, 32'h0, rd, er, qs);
        chk("ro_rd", rd, 32'hDEADBEEF);

        // WO write then read-as-zero
        txn(1, 4, 32'hABCD, 4'hF, 0, 8'h0, 32'h0, rd, er, qs);
        txn(0, 4, 32'h0, 4'h0, 0, 8'h0, 32'h0, rd, er, qs);
        chk("wo_rd", rd, 32'h0);
        chk("wo_err", {31'b0, er}, 32'h0);
        chk("wo_q", regQ[4*32 +: 32], 32'hABCD);

        // Out-of-range address
        txn(0, 9, 32'h0, 4'h0, 0, 8'h0, 32'h0, rd, er, qs);
        chk("oor_rd", rd, 32'h0);
        chk("oor_err", {31'b0, er}, 32'h1);
        txn(1, 9, 32'hFFFFFFFF, 4'hF, 0, 8'h0, 32'h0, rd, er, qs);
        chk("oor_qe", {24'b0, qs}, 32'h0);

        // Zero-mask write
        txn(1, 0, 32'hFFFFFFFF, 4'h0, 0, 8'h0, 32'h0, rd, er, qs);
        chk("m0_qe", {24'b0, qs}, 32'h0);
        chk("m0_q", regQ[31:0], 32'hA522A544);

        // Response stalled for five cycles
        txn(0, 0, 32'h0, 4'h0, 5, 8'h0, 32'h0, rd, er, qs);
        chk("stall_rd", rd, 32'hA522A544);

        // Reset asserted during Exec aborts the transaction
        reqValid = 1'b1; reqWe = 1'b1; reqAddr = 4'h0; reqWdata = 32'hFFFFFFFF; reqBe = 4'hF;
        rspReady = 1'b1;
        tick();
        reqValid = 1'b0;
        expReady = 1'b0;
        #2 rst_n = 1'b0;
        resetToModel();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rspReady = 1'b0;
        repeat (4) tick();
        chk("rst_exec_q0", regQ[31:0], 32'h0);
        chk("rst_exec_q1", regQ[63:32], 32'hFF);
        rspReady = 1'b1;
        txn(0, 1, 32'h0, 4'h0, 0, 8'h0, 32'h0, rd, er, qs);
        chk("post_rst_rd", rd, 32'hFF);

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
